// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the shift sequencer and its single-step shift unit.
package shift_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_PASS  = 3'b000,
        OP_SHL1  = 3'b001,
        OP_SHR1  = 3'b010,
        OP_ROTL1 = 3'b011,
        OP_ROTR1 = 3'b100,
        OP_ASR1  = 3'b101,
        OP_ROTL3 = 3'b110,
        OP_ASR5  = 3'b111
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step 8-bit shift/rotate unit; no widening, 8 bits in and out.
module shift_step
    import shift_seq_pkg::*;
(
    input  shift_op_t         op,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    // One step of the selected shift or rotate
    always_comb begin
        data_out = data_in;
        case (op)
            OP_PASS:  data_out = data_in;
            OP_SHL1:  data_out = {data_in[6:0], 1'b0};
            OP_SHR1:  data_out = {1'b0, data_in[7:1]};
            OP_ROTL1: data_out = {data_in[6:0], data_in[7]};
            OP_ROTR1: data_out = {data_in[0], data_in[7:1]};
            OP_ASR1:  data_out = {data_in[7], data_in[7:1]};
            OP_ROTL3: data_out = {data_in[4:0], data_in[7:5]};
            OP_ASR5:  data_out = {{5{data_in[7]}}, data_in[7:5]};
            default:  data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Applies one shift op a programmed number of times, one step per clock, with valid/ready on both sides.
// Optional macro SHIFT_SEQ_EARLY_EXIT_EN: leave SHIFT as soon as the step reaches a fixed point.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [CNT_W-1:0]  in_count,
    input  logic [DATA_W-1:0] in_data,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    seq_state_t        state_r, state_nxt_s;
    logic [DATA_W-1:0] data_r, data_nxt_s, step_s;
    logic [CNT_W-1:0]  remaining_r, remaining_nxt_s;
    shift_op_t         op_r, op_nxt_s;
    logic              in_ready_r, out_valid_r, busy_r;

    shift_step u_shift_step (
        .op       (op_r),
        .data_in  (data_r),
        .data_out (step_s)
    );

    // Next-state and datapath selection
    always_comb begin
        state_nxt_s     = state_r;
        data_nxt_s      = data_r;
        remaining_nxt_s = remaining_r;
        op_nxt_s        = op_r;
        case (state_r)
            IDLE: begin
                // abort in IDLE blocks acceptance for that cycle
                if (in_valid && !abort) begin
                    data_nxt_s      = in_data;
                    op_nxt_s        = shift_op_t'(in_op);
                    remaining_nxt_s = in_count;
                    if (in_count == CNT_ZERO) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
                    if (step_s == data_r) begin
                        state_nxt_s     = DONE;
                        remaining_nxt_s = CNT_ZERO;
                    end else begin
                        data_nxt_s      = step_s;
                        remaining_nxt_s = remaining_r - CNT_ONE;
                        if (remaining_r == CNT_ONE) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = SHIFT;
                        end
                    end
`else
                    data_nxt_s      = step_s;
                    remaining_nxt_s = remaining_r - CNT_ONE;
                    if (remaining_r == CNT_ONE) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
`endif
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            data_r      <= 8'h00;
            remaining_r <= CNT_ZERO;
            op_r        <= OP_PASS;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            data_r      <= data_nxt_s;
            remaining_r <= remaining_nxt_s;
            op_r        <= op_nxt_s;
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = data_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: per-cycle comparison against a transaction-level model plus literal expectations.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'b000;
    logic [CNT_W-1:0] in_count = 4'd0;
    logic [7:0]       in_data = 8'h00;
    logic             abort = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             busy;

    shift_op_t  st_op;
    logic [7:0] st_in, st_out;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit         pending = 1'b0;
    int         ready_at = 0;
    logic [7:0] exp_res = 8'h00;

    shift_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_count(in_count), .in_data(in_data), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    shift_step u_step_ref (.op(st_op), .data_in(st_in), .data_out(st_out));

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_step(input int op, input logic [7:0] d);
        int v;
        v = int'(d);
        case (op)
            0: v = v;
            1: v = (v * 2) % 256;
            2: v = v / 2;
            3: v = (v * 2) % 256 + v / 128;
            4: v = v / 2 + (v % 2) * 128;
            5: v = v / 2 + (v & 128);
            6: v = (v * 8) % 256 + v / 32;
            7: for (int k = 0; k < 5; k++) v = v / 2 + (v & 128);
            default: v = v;
        endcase
        return v[7:0];
    endfunction

    function automatic logic [7:0] ref_result(input int op, input logic [7:0] d, input int count);
        logic [7:0] r;
        r = d;
        for (int i = 0; i < count; i++) r = ref_step(op, r);
        return r;
    endfunction

    // cycles spent in the shifting phase before the result appears
    function automatic int ref_latency(input int op, input logic [7:0] d, input int count);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        logic [7:0] r, n;
        r = d;
        for (int i = 0; i < count; i++) begin
            n = ref_step(op, r);
            if (n == r) return i + 1;
            r = n;
        end
        return count;
`else
        return count;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: one command outstanding, result due at a computed cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (!pending) begin
            if (in_valid && !abort) begin
                pending  <= 1'b1;
                ready_at <= cyc + 1 + ref_latency(int'(in_op), in_data, int'(in_count));
                exp_res  <= ref_result(int'(in_op), in_data, int'(in_count));
            end
        end else if (abort) begin
            pending <= 1'b0;
        end else if (cyc >= ready_at && out_ready) begin
            pending <= 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, !pending);
            check("busy", busy, pending);
            check("out_valid", out_valid, pending && (cyc >= ready_at));
            if (pending && (cyc >= ready_at)) check("out_data", out_data, exp_res);
        end
    end

    task automatic run_cmd(input logic [7:0] d, input logic [2:0] op, input int cnt,
                           input logic [7:0] lit_res, input int lit_lat, input int hold);
        int  t;
        bit  seen;
        @(negedge clk); #1;
        check("ready_before_cmd", in_ready, 1);
        in_valid = 1'b1; in_data = d; in_op = op; in_count = cnt[CNT_W-1:0];
        @(posedge clk);
        t = cyc;
        #1 in_valid = 1'b0;
        check("model_result_pin", ref_result(int'(op), d, cnt), lit_res);
        check("model_latency_pin", ref_latency(int'(op), d, cnt), lit_lat);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check("latency", cyc - t - 1, lit_lat);
                check("result", out_data, lit_res);
            end else begin
                check("in_ready_while_busy", in_ready, 0);
            end
        end
        if (!seen) check("result_timeout", 0, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, lit_res);
            check("hold_in_ready", in_ready, 0);
        end
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] pats [8];
        pats = '{8'h96, 8'h80, 8'h01, 8'hFF, 8'h00, 8'hA5, 8'h7E, 8'hC3};

        for (int o = 0; o < 8; o++) begin
            for (int p = 0; p < 8; p++) begin
                st_op = shift_op_t'(o[2:0]);
                st_in = pats[p];
                #1;
                check("shift_step", st_out, ref_step(o, pats[p]));
            end
        end
        st_in = 8'h80; st_op = OP_ASR5; #1;
        check("shift_step_asr5_lit", st_out, 8'hFC);

        #10;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1'b1;

        run_cmd(8'b1001_0110, 3'b011, 3, 8'b1011_0100, 3, 0);
        run_cmd(8'h80, 3'b111, 1, 8'hFC, 1, 0);
        run_cmd(8'h80, 3'b101, 7, 8'hFF, 7, 0);
        run_cmd(8'hA5, 3'b001, 0, 8'hA5, 0, 0);
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
        run_cmd(8'hFF, 3'b010, 15, 8'h00, 9, 0);
        run_cmd(8'h5A, 3'b000, 5, 8'h5A, 1, 0);
`else
        run_cmd(8'hFF, 3'b010, 15, 8'h00, 15, 0);
        run_cmd(8'h5A, 3'b000, 5, 8'h5A, 5, 0);
`endif
        run_cmd(8'h0F, 3'b100, 2, 8'hC3, 2, 3);
        run_cmd(8'h01, 3'b001, 4, 8'h10, 4, 0);

        // abort in the second shifting cycle
        @(negedge clk); #1;
        in_valid = 1'b1; in_data = 8'h01; in_op = 3'b001; in_count = 4'd10;
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_result", out_valid, 0);
        end

        // abort in IDLE blocks acceptance
        #1 in_valid = 1'b1; abort = 1'b1; in_count = 4'd2;
        @(posedge clk); #1 in_valid = 1'b0; abort = 1'b0;
        check("idle_abort_blocks", busy, 0);
        check("idle_abort_ready", in_ready, 1);

        // asynchronous reset while shifting
        @(negedge clk); #1;
        in_valid = 1'b1; in_data = 8'h3C; in_op = 3'b100; in_count = 4'd12;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, 8'h00);
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 1);
        #10 rst_n = 1'b1;
        run_cmd(8'hC3, 3'b110, 2, 8'hF0, 2, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that applies one 8-bit shift/rotate operation to an operand a programmed number of times, one step per clock, then returns the result.
- Wraps a combinational single-step shift unit.
- Valid/ready handshake on both the command side and the result side; sits between a command source (switch/FSM front end) and a display/consumer.

Parameters:
- CNT_W, 4, width of the repeat count; max steps = 2**CNT_W-1 (15).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  high only in IDLE.
- in_op  input  3  step op: 000 pass, 001 shl1, 010 shr1, 011 rotl1, 100 rotr1, 101 asr1, 110 rotl3, 111 asr5.
- in_count  input  CNT_W  number of steps to apply.
- in_data  input  8  operand.
- abort  input  1  synchronous cancel of current command.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  8  result register.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, data reg=8'h00, remaining=0, op reg=000. Outputs: in_ready=1 after release, out_valid=0, out_data=8'h00, busy=0. Reset mid-command discards it with no result.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&in_ready: latch in_data, in_op, in_count.
  - Next state: in_count==0 -> DONE; else -> SHIFT.
- SHIFT:
  - Each cycle: data <= step(op, data); remaining <= remaining-1.
  - When remaining==1, go to DONE after that step.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; out_data=data reg, held stable.
  - On out_valid&out_ready -> IDLE.
  - in_ready=0 (no same-cycle accept).
- Latency: accept in cycle T -> out_valid first high in cycle T+1+count. Throughput: one command per count+2 cycles minimum.
- abort:
  - In SHIFT or DONE: next state IDLE; out_valid drops next cycle; data reg retained but no result is presented.
  - In IDLE: ignored, and it blocks acceptance that cycle.
- Step arithmetic:
  - asr uses the sign of bit 7.
  - shl/shr fill with 0.
  - Rotates are circular.
  - No widening; 8-bit in, 8-bit out.
- out_data is registered; there is no combinational path from in_* to out_*.

Optional Feature:
- Macro SHIFT_SEQ_EARLY_EXIT_EN.
- Defined: in SHIFT, if step(op, data)==data (fixed point, e.g. 00 under shr, FF under asr, any value under pass), go to DONE immediately with remaining forced to 0; data is unchanged.
- Undefined: always exactly count steps.
- Result value is identical either way; only latency differs.

Decomposition:
- Package shift_seq_pkg holds:
  - typedef enum logic [2:0] shift_op_t with the op encodings above.
  - typedef enum logic [1:0] seq_state_t {IDLE, SHIFT, DONE}.
  - localparam DATA_W = 8.
- Sub-module shift_step: purely combinational (op, data_in) -> data_out.
  - Instantiated once in the sequencer.
  - Verified standalone against all 8 ops.

Test Plan:
1. in_data=8'b1001_0110, op=011, count=3 accepted in cycle T -> out_valid in T+4, out_data=8'b1011_0100; in_ready=0 in T+1..T+4.
2. in_data=8'h80, op=111, count=1 -> out_data=8'hFC in T+2; in_data=8'h80, op=101, count=7 -> 8'hFF.
3. count=0, op=001, in_data=8'hA5 -> out_data=8'hA5, out_valid in T+1, no SHIFT cycles.
4. op=010, in_data=8'hFF, count=15:
   - Macro undefined: out_data=8'h00 in T+16.
   - Macro defined: 8'h00 in T+10.
   - op=000, count=5, macro defined: out in T+2.
5. DONE with out_ready low 3 cycles -> out_valid and out_data stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle; back-to-back command accepted correctly.
6. abort in the second SHIFT cycle -> IDLE next cycle, out_valid never rises. Separately, rst_n low mid-SHIFT (asynchronous, between edges) -> outputs at reset values immediately; next command unaffected.
